imem_prog_loader: RTL and testbench

//  Hardware program loader and run controller for cpu_top. Replaces the bench-driven

---
 rtl/ldr_pkg.sv | 44 ++++
 rtl/imem_prog_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_prog_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldr_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package ldr_pkg;

    // Command opcodes carried on cmd_op.
    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_VERIFY = 2'd1,
        OP_RUN    = 2'd2,
        OP_RSVD   = 2'd3
    } ldr_op_e;

    // Loader control states; also exported on dbg_state.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_VRD  = 3'd2,
        ST_VCMP = 3'd3,
        ST_RUN  = 3'd4,
        ST_DONE = 3'd5
    } ldr_state_e;

    // CPU status codes as reported on cpu_status.
    localparam logic [3:0] CPU_AOK = 4'd1;
    localparam logic [3:0] CPU_HLT = 4'd2;
    localparam logic [3:0] CPU_ADR = 4'd3;
    localparam logic [3:0] CPU_INS = 4'd4;

    // Error codes reported on err_code.
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_CMD    = 2'd1;
    localparam logic [1:0] ERR_VERIFY = 2'd2;
    localparam logic [1:0] ERR_CPU    = 2'd3;

    // Number of low address bits that must be zero for a beat-aligned address.
    function automatic int beat_shift(input int beat_bytes);
        case (beat_bytes)
            2:       return 1;
            4:       return 2;
            8:       return 3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/imem_prog_loader.sv
// Program loader / run controller: streams beats into imem, reads them back
// for verification, and gates the CPU run enable.
//
// Stream handshake: a beat transfers on a rising sys_clk edge where
// s_valid && s_ready; s_ready depends only on state, never on s_valid.
// Command handshake works the same way with cmd_valid/cmd_ready.
module imem_prog_loader
    import ldr_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int BEAT_BYTES = 1,
    parameter int LEN_W      = 16
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_W-1:0]       cmd_base,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*BEAT_BYTES-1:0] s_data,
    output logic                    imem_wr_en,
    output logic [ADDR_W-1:0]       imem_wr_addr,
    output logic [8*BEAT_BYTES-1:0] imem_wr_data,
    output logic                    imem_rd_en,
    output logic [ADDR_W-1:0]       imem_rd_addr,
    input  logic [8*BEAT_BYTES-1:0] imem_rd_data,
    input  logic [3:0]              cpu_status,
    output logic                    cpu_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic [ADDR_W-1:0]       err_addr,
    output ldr_state_e              dbg_state
);

    if (!(BEAT_BYTES == 1 || BEAT_BYTES == 2 || BEAT_BYTES == 4 || BEAT_BYTES == 8)) begin : g_bad_beat
        $error("imem_prog_loader: BEAT_BYTES must be 1, 2, 4 or 8");
    end

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << beat_shift(BEAT_BYTES)) - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BEAT_BYTES);

    ldr_state_e              state_q, state_d;
    logic [ADDR_W-1:0]       ptr_q;
    logic [LEN_W-1:0]        rem_q;      // beats left, or run-cycle limit for RUN
    logic [LEN_W-1:0]        cnt_q;      // RUN cycles elapsed
    logic [8*BEAT_BYTES-1:0] cap_q;      // beat held for comparison in VCMP
    logic [1:0]              err_code_q;
    logic [ADDR_W-1:0]       err_addr_q;

    ldr_op_e op_in;
    logic    bad_cmd;
    logic    accept;
    logic    run_exit;

    assign op_in    = ldr_op_e'(cmd_op);
    assign bad_cmd  = (|(cmd_base & ALIGN_MASK)) || (op_in == OP_RSVD);
    assign accept   = cmd_valid && (state_q == ST_IDLE);
    assign run_exit = (cpu_status != CPU_AOK) ||
                      ((rem_q != '0) && (cnt_q == rem_q - LEN_W'(1)));

    assign busy      = (state_q != ST_IDLE);
    assign err       = (err_code_q != ERR_NONE);
    assign err_code  = err_code_q;
    assign err_addr  = err_addr_q;
    assign dbg_state = state_q;

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and strobes; memory strobes come straight from the beat handshake.
    always_comb begin
        state_d      = state_q;
        cmd_ready    = 1'b0;
        s_ready      = 1'b0;
        imem_wr_en   = 1'b0;
        imem_wr_addr = '0;
        imem_wr_data = '0;
        imem_rd_en   = 1'b0;
        imem_rd_addr = '0;
        cpu_valid    = 1'b0;
        done         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (bad_cmd) begin
                        state_d = ST_DONE;
                    end else begin
                        case (op_in)
                            OP_LOAD:   state_d = (cmd_len == '0) ? ST_DONE : ST_LOAD;
                            OP_VERIFY: state_d = (cmd_len == '0) ? ST_DONE : ST_VRD;
                            default:   state_d = ST_RUN;
                        endcase
                    end
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    imem_wr_en   = 1'b1;
                    imem_wr_addr = ptr_q;
                    imem_wr_data = s_data;
                    if (rem_q == LEN_W'(1)) state_d = ST_DONE;
                end
            end
            ST_VRD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    imem_rd_en   = 1'b1;
                    imem_rd_addr = ptr_q;
                    state_d      = ST_VCMP;
                end
            end
            ST_VCMP: begin
                state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_VRD;
            end
            ST_RUN: begin
                cpu_valid = 1'b1;
                if (run_exit) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointer, counters, captured beat and sticky error reporting.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            cap_q      <= '0;
            err_code_q <= ERR_NONE;
            err_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ptr_q      <= cmd_base;
                        rem_q      <= cmd_len;
                        cnt_q      <= '0;
                        err_code_q <= bad_cmd ? ERR_CMD : ERR_NONE;
                        err_addr_q <= '0;
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        ptr_q <= ptr_q + STEP;
                        rem_q <= rem_q - LEN_W'(1);
                    end
                end
                ST_VRD: begin
                    if (s_valid) cap_q <= s_data;
                end
                ST_VCMP: begin
                    // Only the first mismatch of a command is recorded.
                    if ((imem_rd_data != cap_q) && (err_code_q == ERR_NONE)) begin
                        err_code_q <= ERR_VERIFY;
                        err_addr_q <= ptr_q;
                    end
                    ptr_q <= ptr_q + STEP;
                    rem_q <= rem_q - LEN_W'(1);
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + LEN_W'(1);
                    if ((cpu_status == CPU_ADR) || (cpu_status == CPU_INS))
                        err_code_q <= ERR_CPU;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Bench for imem_prog_loader: a 1-byte-beat instance with an imem model and
// a 2-byte-beat instance for wrap and alignment behaviour.
module tb_imem_prog_loader;
    import ldr_pkg::*;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    // Shared command fields and CPU status.
    logic [1:0]  cmd_op     = 2'd0;
    logic [9:0]  cmd_base   = 10'd0;
    logic [15:0] cmd_len    = 16'd0;
    logic [3:0]  cpu_status = CPU_AOK;

    // Instance 1: BEAT_BYTES = 1.
    logic       cmd_valid = 1'b0, s_valid = 1'b0;
    logic [7:0] s_data = 8'd0, wr_data, rd_data;
    logic       cmd_ready, s_ready, wr_en, rd_en, cpu_valid, busy, done, err;
    logic [9:0] wr_addr, rd_addr, err_addr;
    logic [1:0] err_code;
    ldr_state_e dbg_state;

    // Instance 2: BEAT_BYTES = 2.
    logic        cmd_valid2 = 1'b0, s_valid2 = 1'b0;
    logic [15:0] s_data2 = 16'd0, wr_data2;
    logic [15:0] rd_data2 = 16'd0;
    logic        cmd_ready2, s_ready2, wr_en2, rd_en2, cpu_valid2, busy2, done2, err2;
    logic [9:0]  wr_addr2, rd_addr2, err_addr2;
    logic [1:0]  err_code2;
    ldr_state_e  dbg_state2;

    int checks   = 0;
    int failures = 0;

    // Scoreboard queues: {addr, data} for writes, addr for reads.
    logic [17:0] wr_q1[$];
    logic [25:0] wr_q2[$];
    logic [9:0]  rd_q1[$];
    logic [7:0]  beats1[$];
    logic [7:0]  mem [0:1023];

    imem_prog_loader #(.ADDR_W(10), .BEAT_BYTES(1), .LEN_W(16)) u_dut (
        .sys_clk(sys_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .imem_wr_en(wr_en), .imem_wr_addr(wr_addr), .imem_wr_data(wr_data),
        .imem_rd_en(rd_en), .imem_rd_addr(rd_addr), .imem_rd_data(rd_data),
        .cpu_status(cpu_status), .cpu_valid(cpu_valid), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .err_addr(err_addr), .dbg_state(dbg_state)
    );

    imem_prog_loader #(.ADDR_W(10), .BEAT_BYTES(2), .LEN_W(16)) u_dut2 (
        .sys_clk(sys_clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .imem_wr_en(wr_en2), .imem_wr_addr(wr_addr2), .imem_wr_data(wr_data2),
        .imem_rd_en(rd_en2), .imem_rd_addr(rd_addr2), .imem_rd_data(rd_data2),
        .cpu_status(cpu_status), .cpu_valid(cpu_valid2), .busy(busy2), .done(done2),
        .err(err2), .err_code(err_code2), .err_addr(err_addr2), .dbg_state(dbg_state2)
    );

    // Clock.
    always #5 sys_clk = ~sys_clk;

    // imem model: byte array, synchronous write, 1-cycle read latency.
    always @(posedge sys_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Scoreboard: memory strobes sampled mid-cycle and matched against expectations.
    logic [17:0] e1;
    logic [25:0] e2;
    logic [9:0]  er;
    always @(negedge sys_clk) begin
        #3;
        if (wr_en) begin
            checks++;
            if (wr_q1.size() == 0) begin
                failures++;
                $display("FAIL wr1_unexpected got addr=%h data=%h, none expected", wr_addr, wr_data);
            end else begin
                e1 = wr_q1.pop_front();
                if ({wr_addr, wr_data} !== e1) begin
                    failures++;
                    $display("FAIL wr1 got addr=%h data=%h exp addr=%h data=%h",
                             wr_addr, wr_data, e1[17:8], e1[7:0]);
                end
            end
        end
        if (rd_en) begin
            checks++;
            if (rd_q1.size() == 0) begin
                failures++;
                $display("FAIL rd1_unexpected got addr=%h, none expected", rd_addr);
            end else begin
                er = rd_q1.pop_front();
                if (rd_addr !== er) begin
                    failures++;
                    $display("FAIL rd1 got addr=%h exp addr=%h", rd_addr, er);
                end
            end
        end
        if (wr_en2) begin
            checks++;
            if (wr_q2.size() == 0) begin
                failures++;
                $display("FAIL wr2_unexpected got addr=%h data=%h, none expected", wr_addr2, wr_data2);
            end else begin
                e2 = wr_q2.pop_front();
                if ({wr_addr2, wr_data2} !== e2) begin
                    failures++;
                    $display("FAIL wr2 got addr=%h data=%h exp addr=%h data=%h",
                             wr_addr2, wr_data2, e2[25:16], e2[15:0]);
                end
            end
        end
    end

    // Issue one command to instance 1 (which=0) or 2 (which=1); returns at the
    // falling edge right after the accepting edge.
    task automatic do_cmd(input bit which, input logic [1:0] op, input logic [9:0] base,
                          input logic [15:0] len);
        @(negedge sys_clk);
        cmd_op = op; cmd_base = base; cmd_len = len;
        checks++;
        if (((which == 1'b0) ? cmd_ready : cmd_ready2) !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready got 0 exp 1 (inst %0d)", which);
        end
        if (which == 1'b0) cmd_valid = 1'b1;
        else               cmd_valid2 = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    endtask

    // Drive n beats from beats1 into instance 1, s_valid held high throughout.
    task automatic stream1(input int n, output int cycles);
        int i;
        bit hs;
        i = 0; cycles = 0;
        while (i < n && cycles < 64) begin
            s_valid = 1'b1; s_data = beats1[i]; hs = s_ready;
            @(posedge sys_clk);
            cycles++;
            if (hs) i++;
            @(negedge sys_clk);
        end
        s_valid = 1'b0;
        checks++;
        if (i != n) begin
            failures++;
            $display("FAIL stream1_timeout got %0d beats exp %0d", i, n);
        end
    endtask

    task automatic test_reset;
        logic [48:0] obs;
        repeat (3) @(negedge sys_clk);
        obs = {cmd_ready, s_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr, cpu_valid,
               busy, done, err, err_code, err_addr, dbg_state == ST_IDLE};
        checks++;
        if (obs !== {1'b1, 47'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs got %h exp %h", obs, {1'b1, 47'd0, 1'b1});
        end
        rst = 1'b0;
    endtask

    task automatic test_load;
        int cyc;
        beats1 = '{8'h30, 8'hF2, 8'h0A, 8'h00};
        for (int i = 0; i < 4; i++) wr_q1.push_back({10'(i), beats1[i]});
        do_cmd(1'b0, OP_LOAD, 10'h000, 16'd4);
        stream1(4, cyc);
        checks++;
        if (cyc != 4) begin failures++; $display("FAIL load_cycles got %0d exp 4", cyc); end
        checks++;
        if ({done, err} !== 2'b10) begin failures++; $display("FAIL load_done got done=%b err=%b exp done=1 err=0", done, err); end
        @(negedge sys_clk);
        checks++;
        if ({done, busy} !== 2'b00) begin failures++; $display("FAIL load_done_pulse got done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_wrap;
        int i, cyc;
        logic [15:0] b2 [4];
        logic [9:0]  a2 [4];
        bit hs;
        b2 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        a2 = '{10'h3FE, 10'h000, 10'h002, 10'h004};
        for (int k = 0; k < 4; k++) wr_q2.push_back({a2[k], b2[k]});
        do_cmd(1'b1, OP_LOAD, 10'h3FE, 16'd4);
        i = 0; cyc = 0;
        while (i < 4 && cyc < 64) begin
            s_valid2 = 1'b1; s_data2 = b2[i]; hs = s_ready2;
            @(posedge sys_clk);
            cyc++;
            if (hs) i++;
            @(negedge sys_clk);
        end
        s_valid2 = 1'b0;
        checks++;
        if ({i == 4, done2, err2} !== 3'b110) begin
            failures++;
            $display("FAIL wrap_done got beats=%0d done=%b err=%b exp 4 1 0", i, done2, err2);
        end
    endtask

    task automatic test_verify(input logic [7:0] b2, input logic [1:0] exp_code,
                               input logic [9:0] exp_addr);
        int cyc;
        beats1 = '{8'h30, 8'hF2, b2, 8'h00};
        for (int i = 0; i < 4; i++) rd_q1.push_back(10'(i));
        do_cmd(1'b0, OP_VERIFY, 10'h000, 16'd4);
        stream1(4, cyc);
        checks++;
        if (cyc != 7) begin failures++; $display("FAIL verify_cycles got %0d exp 7", cyc); end
        @(negedge sys_clk);
        checks++;
        if ({done, err_code, err_addr} !== {1'b1, exp_code, exp_addr}) begin
            failures++;
            $display("FAIL verify_result got done=%b code=%0d addr=%h exp 1 %0d %h",
                     done, err_code, err_addr, exp_code, exp_addr);
        end
    endtask

    task automatic test_run_len;
        int n;
        cpu_status = CPU_AOK;
        do_cmd(1'b0, OP_RUN, 10'h000, 16'd20);
        n = 0;
        while (cpu_valid && n < 100) begin n++; @(negedge sys_clk); end
        checks++;
        if (n != 20) begin failures++; $display("FAIL run_len_cycles got %0d exp 20", n); end
        checks++;
        if ({done, err} !== 2'b10) begin failures++; $display("FAIL run_len_done got done=%b err=%b exp 1 0", done, err); end
    endtask

    task automatic test_run_fault(input logic [3:0] st, input logic [1:0] exp_code);
        int n;
        cpu_status = CPU_AOK;
        do_cmd(1'b0, OP_RUN, 10'h000, 16'd0);
        n = 0;
        while (cpu_valid && n < 100) begin
            n++;
            if (n == 7) cpu_status = st;
            @(negedge sys_clk);
        end
        checks++;
        if (n != 7) begin failures++; $display("FAIL run_stop_cycles status=%0d got %0d exp 7", st, n); end
        checks++;
        if ({done, err_code} !== {1'b1, exp_code}) begin
            failures++;
            $display("FAIL run_stop_result status=%0d got done=%b code=%0d exp 1 %0d", st, done, err_code, exp_code);
        end
        cpu_status = CPU_AOK;
    endtask

    task automatic test_bad_cmd;
        // Misaligned base on the 2-byte instance, with a beat on offer that must be ignored.
        s_valid2 = 1'b1; s_data2 = 16'hDEAD;
        do_cmd(1'b1, OP_LOAD, 10'h001, 16'd4);
        checks++;
        if ({done2, err2, err_code2} !== {2'b11, ERR_CMD}) begin
            failures++;
            $display("FAIL misalign got done=%b err=%b code=%0d exp 1 1 1", done2, err2, err_code2);
        end
        @(negedge sys_clk);
        s_valid2 = 1'b0;
        do_cmd(1'b0, 2'd3, 10'h000, 16'd4);
        checks++;
        if ({done, err_code} !== {1'b1, ERR_CMD}) begin
            failures++;
            $display("FAIL bad_op got done=%b code=%0d exp 1 1", done, err_code);
        end
        do_cmd(1'b0, OP_LOAD, 10'h010, 16'd0);
        checks++;
        if ({done, err_code} !== {1'b1, ERR_NONE}) begin
            failures++;
            $display("FAIL zero_len got done=%b code=%0d exp 1 0", done, err_code);
        end
    endtask

    task automatic test_reset_mid_load;
        int cyc;
        logic [48:0] obs;
        beats1 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        wr_q1.push_back({10'h100, 8'hA1});
        wr_q1.push_back({10'h101, 8'hA2});
        do_cmd(1'b0, OP_LOAD, 10'h100, 16'd8);
        stream1(2, cyc);
        #1;
        rst = 1'b1; s_valid = 1'b1; s_data = 8'hA3;
        #1;
        obs = {cmd_ready, s_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr, cpu_valid,
               busy, done, err, err_code, err_addr, dbg_state == ST_IDLE};
        checks++;
        if (obs !== {1'b1, 47'd0, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset_outputs got %h exp %h", obs, {1'b1, 47'd0, 1'b1});
        end
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        s_valid = 1'b0;
        checks++;
        if ({busy, wr_q1.size() == 0} !== 2'b01) begin
            failures++;
            $display("FAIL post_reset_idle got busy=%b pending=%0d exp 0 0", busy, wr_q1.size());
        end
        // A fresh load after the abandoned one must run normally.
        beats1 = '{8'h5A, 8'h6B, 8'h7C};
        for (int i = 0; i < 3; i++) wr_q1.push_back({10'h200 + 10'(i), beats1[i]});
        do_cmd(1'b0, OP_LOAD, 10'h200, 16'd3);
        stream1(3, cyc);
        checks++;
        if ({cyc == 3, done, err} !== 3'b110) begin
            failures++;
            $display("FAIL reload got cycles=%0d done=%b err=%b exp 3 1 0", cyc, done, err);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_wrap();
        test_verify(8'h0B, ERR_VERIFY, 10'h002);
        test_verify(8'h0A, ERR_NONE, 10'h000);
        test_run_len();
        test_run_fault(CPU_HLT, ERR_NONE);
        test_run_fault(CPU_ADR, ERR_CPU);
        test_run_fault(CPU_INS, ERR_CPU);
        test_bad_cmd();
        test_reset_mid_load();
        repeat (3) @(negedge sys_clk);
        checks++;
        if (wr_q1.size() + wr_q2.size() + rd_q1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending exp 0",
                     wr_q1.size() + wr_q2.size() + rd_q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
